// File: rtl/result_display_driver.sv
// ---------------------------------------------------------------------------
// result_display_driver
//
// Takes the registered 16-bit result of the add/sub/mult stage and drives a
// 4-digit common-anode seven-segment display.
//   * DEC mode: sequential double-dabble (shift-add-3), one bit per cycle.
//   * HEX mode: captured nibbles are shown directly. They go through the same
//     FSM path, so latency does not depend on the mode.
//   * The digits are time-multiplexed; each one stays enabled for REFRESH_DIV
//     clock cycles.
//
// Compile-time option:
//   LEADING_ZERO_BLANK_EN - when defined, leading zeros above digit 0 are
//   blanked in DEC mode. Overflow turns blanking off, and HEX mode is never
//   blanked. When undefined, every digit is always shown.
//
// DIGITS*4 must equal BITS: HEX mode maps one nibble onto each digit.
// ---------------------------------------------------------------------------
module result_display_driver #(
  parameter int BITS        = 16,
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BITS-1:0]   RESULT,
  input  logic              RESULT_VALID,
  input  logic              DEC_MODE,
  output logic [6:0]        SEG,
  output logic              DP,
  output logic [DIGITS-1:0] AN,
  output logic              BUSY
);

  // One extra BCD digit catches values above 9999. It drives the overflow flag.
  localparam int BCD_DIGITS = DIGITS + 1;
  localparam int BCDW       = 4 * BCD_DIGITS;
  localparam int BIT_W      = (BITS > 1)        ? $clog2(BITS)        : 1;
  localparam int CNT_W      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W      = (DIGITS > 1)      ? $clog2(DIGITS)      : 1;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_e;

  // -------------------------------------------------------------------------
  // Conversion FSM state
  // -------------------------------------------------------------------------
  state_e            state_q;
  logic [BIT_W-1:0]  bitcnt_q;
  logic [BCDW-1:0]   bcd_q;
  logic [BITS-1:0]   bin_q;
  logic [BITS-1:0]   val_q;       // captured value, used for the HEX digits
  logic              dec_q;       // captured mode
  logic              pend_q;
  logic [BITS-1:0]   pend_val_q;
  logic              pend_dec_q;
  logic              busy_q;

  // -------------------------------------------------------------------------
  // Display and scan state
  // -------------------------------------------------------------------------
  logic [DIGITS-1:0][3:0] disp_q, disp_d;
  logic                   ovf_q, ovf_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [6:0]             seg_q, seg_d;
  logic                   dp_q, dp_d;
  logic [DIGITS-1:0]      an_q, an_d;
  logic                   load_w;
  logic [DIGITS-1:0][3:0] new_digits_w;

`ifdef LEADING_ZERO_BLANK_EN
  logic                   disp_dec_q, disp_dec_d;
  logic [DIGITS-1:0]      blank_w;
  logic                   zero_run_w;
`endif

  // One double-dabble step: add 3 to every BCD nibble >= 5, then shift the
  // whole {bcd, bin} register left by one bit.
  function automatic logic [BCDW+BITS-1:0] dd_step(input logic [BCDW-1:0] bcd,
                                                   input logic [BITS-1:0] bin);
    logic [BCDW-1:0] adj;
    adj = bcd;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    end
    return {adj, bin} << 1;
  endfunction

  // Active-low segment pattern {g,f,e,d,c,b,a} for one hex digit.
  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'h0: glyph = 7'h40;
      4'h1: glyph = 7'h79;
      4'h2: glyph = 7'h24;
      4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19;
      4'h5: glyph = 7'h12;
      4'h6: glyph = 7'h02;
      4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00;
      4'h9: glyph = 7'h10;
      4'hA: glyph = 7'h08;
      4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h46;
      4'hD: glyph = 7'h21;
      4'hE: glyph = 7'h06;
      default: glyph = 7'h0E;
    endcase
  endfunction

  // Conversion FSM: capture a value, shift it BITS times, then hand over in DONE.
  // NOTE: every register in a clocked block uses <=, so all registers in the
  // block update together at the edge and none sees another's new value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      bitcnt_q   <= '0;
      bcd_q      <= '0;
      bin_q      <= '0;
      val_q      <= '0;
      dec_q      <= 1'b0;
      pend_q     <= 1'b0;
      pend_val_q <= '0;
      pend_dec_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (RESULT_VALID) begin
            val_q    <= RESULT;
            bin_q    <= RESULT;
            dec_q    <= DEC_MODE;
            bcd_q    <= '0;
            bitcnt_q <= BIT_W'(BITS - 1);
            state_q  <= S_SHIFT;
            busy_q   <= 1'b1;
          end
        end

        S_SHIFT: begin
          {bcd_q, bin_q} <= dd_step(bcd_q, bin_q);
          if (bitcnt_q == '0) state_q <= S_DONE;
          else                bitcnt_q <= bitcnt_q - 1'b1;
          // A strobe during a conversion is parked. A later strobe overwrites it.
          if (RESULT_VALID) begin
            pend_q     <= 1'b1;
            pend_val_q <= RESULT;
            pend_dec_q <= DEC_MODE;
          end
        end

        S_DONE: begin
          // A strobe arriving in DONE counts as the newest pending value, so the
          // restart uses it directly instead of the parked one.
          if (RESULT_VALID || pend_q) begin
            val_q    <= RESULT_VALID ? RESULT   : pend_val_q;
            bin_q    <= RESULT_VALID ? RESULT   : pend_val_q;
            dec_q    <= RESULT_VALID ? DEC_MODE : pend_dec_q;
            bcd_q    <= '0;
            bitcnt_q <= BIT_W'(BITS - 1);
            pend_q   <= 1'b0;
            state_q  <= S_SHIFT;
          end else begin
            state_q  <= S_IDLE;
            busy_q   <= 1'b0;
          end
        end

        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign load_w = (state_q == S_DONE);

  // Digits presented by a finishing conversion: BCD in DEC mode, raw nibbles in HEX.
  always_comb begin
    // NOTE: each variable gets a default before any branch, so no latch is
    // inferred when some path leaves it unassigned.
    new_digits_w = '0;
    for (int i = 0; i < DIGITS; i++) begin
      new_digits_w[i] = dec_q ? bcd_q[4*i +: 4] : val_q[4*i +: 4];
    end
  end

  // Next display contents and scan position.
  // SEG, AN and DP are decoded from these next values. One register stage
  // therefore keeps all three outputs aligned with the same digit.
  always_comb begin
    disp_d = disp_q;
    ovf_d  = ovf_q;
    if (load_w) begin
      disp_d = new_digits_w;
      ovf_d  = dec_q && (bcd_q[BCDW-1 -: 4] != 4'd0);
    end

    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Leading-zero mask: digit i is blank when it and every digit above it are 0.
  // Digit 0 is never blanked, and blanking is off on overflow or in HEX mode.
  always_comb begin
    disp_dec_d = load_w ? dec_q : disp_dec_q;
    blank_w    = '0;
    zero_run_w = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      zero_run_w = zero_run_w && (disp_d[i] == 4'd0);
      blank_w[i] = disp_dec_d && !ovf_d && zero_run_w;
    end
  end
`endif

  // Output decode for the digit that is selected next.
  always_comb begin
    seg_d = glyph(disp_d[idx_d]);
`ifdef LEADING_ZERO_BLANK_EN
    if (blank_w[idx_d]) seg_d = SEG_BLANK;
`endif
    an_d = ~(DIGITS'(1) << idx_d);
    dp_d = ~ovf_d;
  end

  // Display registers, scan counters and the registered outputs.
  // The display digits are reset along with the rest: after a reset the panel
  // shows 0000, never leftover contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_q <= '0;
      ovf_q  <= 1'b0;
      cnt_q  <= '0;
      idx_q  <= '0;
      seg_q  <= SEG_BLANK;
      dp_q   <= 1'b1;
      an_q   <= '1;
`ifdef LEADING_ZERO_BLANK_EN
      disp_dec_q <= 1'b0;
`endif
    end else begin
      disp_q <= disp_d;
      ovf_q  <= ovf_d;
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
      an_q   <= an_d;
`ifdef LEADING_ZERO_BLANK_EN
      disp_dec_q <= disp_dec_d;
`endif
    end
  end

  assign SEG  = seg_q;
  assign DP   = dp_q;
  assign AN   = an_q;
  assign BUSY = busy_q;

endmodule

// File: tb/tb_result_display_driver.sv
// ---------------------------------------------------------------------------
// tb_result_display_driver
//
// Directed, self-checking bench for result_display_driver with REFRESH_DIV=4.
// Expected glyphs come from the bench's own segment table. Inputs change 1 ns
// after a rising edge, and outputs are sampled at that same point.
// ---------------------------------------------------------------------------
module tb_result_display_driver;

  localparam int BITS        = 16;
  localparam int DIGITS      = 4;
  localparam int REFRESH_DIV = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [BITS-1:0]   RESULT = '0;
  logic              RESULT_VALID = 1'b0;
  logic              DEC_MODE = 1'b0;
  logic [6:0]        SEG;
  logic              DP;
  logic [DIGITS-1:0] AN;
  logic              BUSY;

  int passed = 0;
  int total  = 0;

  result_display_driver #(
    .BITS        (BITS),
    .DIGITS      (DIGITS),
    .REFRESH_DIV (REFRESH_DIV)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .RESULT       (RESULT),
    .RESULT_VALID (RESULT_VALID),
    .DEC_MODE     (DEC_MODE),
    .SEG          (SEG),
    .DP           (DP),
    .AN           (AN),
    .BUSY         (BUSY)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'h0: glyph = 7'h40;  4'h1: glyph = 7'h79;  4'h2: glyph = 7'h24;
      4'h3: glyph = 7'h30;  4'h4: glyph = 7'h19;  4'h5: glyph = 7'h12;
      4'h6: glyph = 7'h02;  4'h7: glyph = 7'h78;  4'h8: glyph = 7'h00;
      4'h9: glyph = 7'h10;  4'hA: glyph = 7'h08;  4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h46;  4'hD: glyph = 7'h21;  4'hE: glyph = 7'h06;
      default: glyph = 7'h0E;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle RESULT_VALID strobe. On return the bench sits in cycle N+1.
  task automatic strobe(input logic [BITS-1:0] val, input logic dec);
    RESULT       = val;
    DEC_MODE     = dec;
    RESULT_VALID = 1'b1;
    tick();
    RESULT_VALID = 1'b0;
  endtask

  // Work out which digit AN currently selects and compare SEG with that digit's glyph.
  task automatic check_view(input string tag, input logic [15:0] digits);
    logic [6:0] exp;
    case (AN)
      4'b1110: exp = glyph(digits[3:0]);
      4'b1101: exp = glyph(digits[7:4]);
      4'b1011: exp = glyph(digits[11:8]);
      4'b0111: exp = glyph(digits[15:12]);
      default: exp = 7'h7F;
    endcase
    check({tag, "_an_onehot"}, 32'(AN == 4'b1110 || AN == 4'b1101 ||
                                   AN == 4'b1011 || AN == 4'b0111), 32'd1);
    check({tag, "_seg"}, 32'(SEG), 32'(exp));
  endtask

  // Wait for each digit enable in turn, from digit 3 down to 0, and check SEG and DP.
  task automatic scan_check(input string tag, input logic [15:0] digits, input logic dp_exp);
    logic [3:0] want;
    for (int i = 3; i >= 0; i--) begin
      int guard;
      want  = ~(4'b0001 << i);
      guard = 0;
      while (AN !== want && guard < 40) begin
        tick();
        guard++;
      end
      check($sformatf("%s_an%0d", tag, i), 32'(AN), 32'(want));
      check($sformatf("%s_seg%0d", tag, i), 32'(SEG), 32'(glyph(digits[4*i +: 4])));
      check($sformatf("%s_dp%0d", tag, i), 32'(DP), 32'(dp_exp));
    end
  endtask

  // Count the consecutive BUSY-high cycles, stopping at a fixed bound.
  task automatic busy_cycles(output int n);
    n = 0;
    while (BUSY === 1'b1 && n < 100) begin
      n++;
      tick();
    end
  endtask

  initial begin
    int n;
    int c;

    // ---- Reset held, then released ----------------------------------------
    tick(); tick(); tick();
    check("rst_seg",  32'(SEG),  32'h7F);
    check("rst_an",   32'(AN),   32'hF);
    check("rst_dp",   32'(DP),   32'd1);
    check("rst_busy", 32'(BUSY), 32'd0);
    rst = 1'b0;
    tick();
    check("rel_an",   32'(AN),   32'b1110);
    check("rel_seg",  32'(SEG),  32'h40);
    check("rel_busy", 32'(BUSY), 32'd0);

    // ---- DEC 1234 -----------------------------------------------------------
    strobe(16'd1234, 1'b1);
    busy_cycles(n);
    check("dec1234_busy_len", 32'(n), 32'd17);
    scan_check("dec1234", 16'h1234, 1'b1);

    // ---- HEX BEEF, exact latency -------------------------------------------
    strobe(16'hBEEF, 1'b0);                     // now in cycle N+1
    for (int k = 0; k < 16; k++) tick();        // cycle N+17: still old value
    check("beef_busy_n17", 32'(BUSY), 32'd1);
    check_view("beef_old_n17", 16'h1234);
    tick();                                     // cycle N+18: new value
    check("beef_busy_n18", 32'(BUSY), 32'd0);
    check_view("beef_new_n18", 16'hBEEF);
    scan_check("beef", 16'hBEEF, 1'b1);

    // ---- DEC 65025: overflow ------------------------------------------------
    strobe(16'd65025, 1'b1);
    busy_cycles(n);
    check("ovf_busy_len", 32'(n), 32'd17);
    scan_check("ovf", 16'h5025, 1'b0);

    // ---- Pending: 100, then 7 and 42 strobed two and four cycles later -----
    strobe(16'd100, 1'b1);                      // cycle 1
    c = 1;
    n = int'(BUSY);
    tick(); c++; n += int'(BUSY);               // cycle 2
    strobe(16'd7, 1'b1);  c++; n += int'(BUSY); // cycle 3
    tick(); c++; n += int'(BUSY);               // cycle 4
    strobe(16'd42, 1'b1); c++;                  // cycle 5
    while (BUSY === 1'b1 && c < 80) begin
      n++;
      if (c == 18) check_view("pend_first_0100", 16'h0100);
      tick();
      c++;
    end
    check("pend_busy_len", 32'(n), 32'd34);
    check("pend_busy_end_cycle", 32'(c), 32'd35);
    scan_check("pend_last", 16'h0042, 1'b1);

    // ---- Reset in the middle of a 9999 conversion ---------------------------
    strobe(16'd9999, 1'b1);                     // cycle N+1: first SHIFT cycle
    for (int k = 0; k < 8; k++) tick();
    check("mid_busy_before", 32'(BUSY), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_seg",  32'(SEG),  32'h7F);
    check("mid_rst_an",   32'(AN),   32'hF);
    check("mid_rst_dp",   32'(DP),   32'd1);
    check("mid_rst_busy", 32'(BUSY), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check("mid_rel_busy", 32'(BUSY), 32'd0);
    scan_check("mid_zero", 16'h0000, 1'b1);
    check("mid_still_idle", 32'(BUSY), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
